// File: rtl/fpcvt_sched_pkg.sv
// Shared definitions for the fpcvt_sched block: FSM state encoding and
// operand/result field widths.
package fpcvt_sched_pkg;

    localparam int DATA_W = 12;
    localparam int E_W    = 3;
    localparam int F_W    = 4;
    localparam int ID_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fpcvt_sched_fpcvt.sv
// FPCVT converter: 12-bit two's-complement operand to a sign / 3-bit exponent /
// 4-bit significand value, where value ~= F * 2^E.
// The magnitude is normalised so F holds the four bits starting at the leading
// one (or the raw low bits when the magnitude is below 16). The bit just below
// F rounds the result up. A rounding carry out of F renormalises to F=1000 with
// E+1, and saturates at E=7, F=1111. -2048 has no positive counterpart, so its
// magnitude is clamped to 2047, which then saturates through the same path.
module fpcvt_sched_fpcvt
    import fpcvt_sched_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    output logic              s,
    output logic [E_W-1:0]    e,
    output logic [F_W-1:0]    f
);

    logic [DATA_W-1:0] mag;
    logic [E_W-1:0]    exp_raw;
    logic [F_W-1:0]    sig_raw;
    logic              rnd;
    logic [F_W:0]      sig_sum;

    // Sign/magnitude split, leading-one search, truncation and rounding.
    always_comb begin
        s   = d[DATA_W-1];
        mag = s ? (~d + 1'b1) : d;
        if (mag[DATA_W-1]) begin
            mag = {1'b0, {(DATA_W-1){1'b1}}};
        end

        // Highest set bit at position F_W-1+k gives exponent k.
        exp_raw = '0;
        for (int i = F_W; i < DATA_W - 1; i++) begin
            if (mag[i]) begin
                exp_raw = E_W'(i - F_W + 1);
            end
        end

        sig_raw = F_W'(mag >> exp_raw);
        rnd     = (exp_raw != '0) ? mag[exp_raw - 1'b1] : 1'b0;
        sig_sum = {1'b0, sig_raw} + {{F_W{1'b0}}, rnd};

        e = exp_raw;
        f = sig_sum[F_W-1:0];
        if (sig_sum[F_W]) begin
            if (exp_raw == '1) begin
                e = '1;
                f = '1;
            end else begin
                e = exp_raw + 1'b1;
                f = {1'b1, {(F_W-1){1'b0}}};
            end
        end
    end

endmodule

// File: rtl/fpcvt_sched.sv
// fpcvt_sched: round-robin arbiter in front of a single FPCVT converter.
// One request is accepted at a time; its result is presented two cycles after
// the accept and held until the consumer takes it.
//
// Handshakes: a request transfers when req_valid[i] & req_ready[i] at a rising
// edge; req_ready is a combinational one-hot grant, only ever offered in IDLE
// and never while rst is high. A result transfers when out_valid & out_ready;
// out_* stay stable while out_valid is high and out_ready is low.
module fpcvt_sched
    import fpcvt_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_d,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_s,
    output logic [E_W-1:0]          out_e,
    output logic [F_W-1:0]          out_f,
    output logic [ID_W-1:0]         out_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        conv_count,
    output logic [1:0]              fsm_state
);

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [DATA_W-1:0] d_reg;
    logic [ID_W-1:0]   id_reg;

    logic [2*N_REQ-2:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    grant_off;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_hit;
    logic               accept;
    logic               result_done;

    logic              cvt_s;
    logic [E_W-1:0]    cvt_e;
    logic [F_W-1:0]    cvt_f;

    // Rotate the requests so rr_ptr lands at bit 0, take the lowest set bit,
    // then rotate the winner's index back.
    always_comb begin
        req_dbl   = {req_valid[N_REQ-2:0], req_valid};
        req_rot   = req_dbl[rr_ptr +: N_REQ];
        grant_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_off = ID_W'(i);
            end
        end
        grant_idx = rr_ptr + grant_off;
        grant_hit = |req_valid;
    end

    assign accept      = |(req_valid & req_ready);
    assign result_done = out_valid & out_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: IDLE -> CONV on accept, CONV -> HOLD always,
    // HOLD -> IDLE when the result is taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = CONV;
            CONV:                   state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // FSM outputs: grant only in IDLE outside reset, result valid only in HOLD.
    always_comb begin
        req_ready = '0;
        if ((state == IDLE) && !rst && grant_hit) begin
            req_ready = N_REQ'(1) << grant_idx;
        end
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
        fsm_state = state;
    end

    // Datapath: capture the granted operand, register the converter result in
    // CONV, advance the round-robin pointer and count completed results.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            d_reg      <= '0;
            id_reg     <= '0;
            out_s      <= 1'b0;
            out_e      <= '0;
            out_f      <= '0;
            conv_count <= '0;
        end else begin
            if (accept) begin
                d_reg  <= req_d[int'(grant_idx)*DATA_W +: DATA_W];
                id_reg <= grant_idx;
                rr_ptr <= grant_idx + 1'b1;
            end
            if (state == CONV) begin
                out_s <= cvt_s;
                out_e <= cvt_e;
                out_f <= cvt_f;
            end
            if (result_done) begin
                conv_count <= conv_count + 1'b1;
            end
        end
    end

    assign out_id = id_reg;

    fpcvt_sched_fpcvt u_fpcvt (
        .d (d_reg),
        .s (cvt_s),
        .e (cvt_e),
        .f (cvt_f)
    );

endmodule

// File: tb/tb_fpcvt_sched.sv
// Testbench for fpcvt_sched: directed cases for the documented examples and
// boundaries, then randomized traffic with backpressure, checked against a
// behavioural reference of the conversion and round-robin rules.
module tb_fpcvt_sched;

    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req_valid;
    logic [47:0]    req_d;
    logic [3:0]     req_ready;
    logic           out_valid;
    logic           out_ready;
    logic           out_s;
    logic [2:0]     out_e;
    logic [3:0]     out_f;
    logic [1:0]     out_id;
    logic           busy;
    logic [CW-1:0]  conv_count;
    logic [1:0]     fsm_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fpcvt_sched #(.N_REQ(4), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_d      (req_d),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_e      (out_e),
        .out_f      (out_f),
        .out_id     (out_id),
        .busy       (busy),
        .conv_count (conv_count),
        .fsm_state  (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [9:0]  exp_q[$];
    int          model_ptr;
    int          model_count;
    int          last_accept;
    int          last_grant;
    logic [9:0]  last_obs;
    logic [11:0] d_in[4];
    logic [11:0] edge_vals[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference conversion: round the magnitude to a 4-bit significand times
    // a power of two, rounding half up, saturating at 15*2^7.
    function automatic logic [7:0] ref_cvt(input logic [11:0] d);
        int  v, mag, e, f;
        logic s;
        v   = int'($signed(d));
        s   = (v < 0);
        mag = s ? -v : v;
        if (mag > 2047) mag = 2047;
        e = 0;
        while (e < 7 && (mag >> e) > 15) e++;
        f = mag >> e;
        if (e > 0 && ((mag >> (e - 1)) & 1) == 1) f++;
        if (f == 16) begin
            f = 8;
            e++;
        end
        if (e == 8) begin
            e = 7;
            f = 15;
        end
        return {s, 3'(e), 4'(f)};
    endfunction

    // Reference arbitration: first valid requester at or after the pointer.
    function automatic int pick(input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_d[i*12 +: 12] = d_in[i];
    endtask

    task automatic drive_noise();
        req_valid = 4'($urandom);
        req_d     = 48'({$urandom, $urandom});
    endtask

    // ---------------- driver: one full transaction ----------------
    // Starts in the IDLE cycle, ends on the edge that completes the result
    // handshake, so back-to-back calls are spaced by exactly three cycles.
    task automatic run_txn(input logic [3:0] mask, input int stall, input bit noise,
                           input bit check_spacing);
        int         g;
        int         acc_cyc;
        logic [9:0] exp;
        logic [9:0] got;
        @(negedge clk);
        req_valid = mask;
        drive_data();
        out_ready = 1'b0;
        #1;
        check("idle_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        check("count", conv_count, model_count);
        g = pick(mask);
        check("grant", req_ready, 32'(1) << g);
        exp     = {ref_cvt(d_in[g]), 2'(g)};
        acc_cyc = cyc;
        if (check_spacing && last_accept >= 0) check("spacing", acc_cyc - last_accept, 3);
        last_accept = acc_cyc;
        last_grant  = g;
        @(posedge clk);
        model_ptr = (g + 1) % 4;

        @(negedge clk);
        if (noise) drive_noise();
        #1;
        check("conv_ready", req_ready, 0);
        check("conv_valid", out_valid, 0);
        check("conv_busy", busy, 1);
        check("conv_state", fsm_state, 1);
        exp_q.push_back(exp);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (noise) drive_noise();
            out_ready = 1'b0;
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_busy", busy, 1);
            check("hold_ready", req_ready, 0);
            check("hold_stable", {out_s, out_e, out_f, out_id}, exp_q[0]);
        end

        @(negedge clk);
        if (noise) drive_noise();
        out_ready = 1'b1;
        #1;
        check("hs_valid", out_valid, 1);
        check("hs_ready", req_ready, 0);
        got      = {out_s, out_e, out_f, out_id};
        last_obs = got;
        check("result", got, exp_q.pop_front());
        @(posedge clk);
        model_count = (model_count + 1) % (1 << CW);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int g;
        edge_vals[0] = 12'h800; edge_vals[1] = 12'h7FF;
        edge_vals[2] = 12'h000; edge_vals[3] = 12'hFFF;
        edge_vals[4] = 12'h801; edge_vals[5] = 12'h00F;
        edge_vals[6] = 12'h01F; edge_vals[7] = 12'h7C0;

        rst         = 1'b1;
        req_valid   = 4'hF;
        req_d       = 48'({$urandom, $urandom});
        out_ready   = 1'b0;
        model_ptr   = 0;
        model_count = 0;
        last_accept = -1;
        last_grant  = 0;
        last_obs    = '0;

        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_ready", req_ready, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", conv_count, 0);
        check("rst_outs", {out_s, out_e, out_f, out_id}, 0);
        check("rst_state", fsm_state, 0);
        check("rst_rr", req_ready, 4'b0001);
        req_valid = 4'h0;

        // Single request, then rounding.
        for (int i = 0; i < 4; i++) d_in[i] = 12'($urandom);
        d_in[0] = 12'h02C;
        run_txn(4'b0001, 0, 1'b0, 1'b0);
        check("single", last_obs, {1'b0, 3'd2, 4'b1011, 2'd0});
        d_in[2] = 12'h02E;
        run_txn(4'b0100, 0, 1'b0, 1'b0);
        check("round", last_obs, {1'b0, 3'd2, 4'b1100, 2'd2});

        // Backpressure with input noise while not granted.
        d_in[1] = 12'($urandom);
        run_txn(4'b0010, 5, 1'b1, 1'b0);

        // Boundaries.
        d_in[3] = 12'h800;
        run_txn(4'b1000, 0, 1'b0, 1'b0);
        check("sat", last_obs, {1'b1, 3'd7, 4'b1111, 2'd3});
        d_in[0] = 12'h000;
        run_txn(4'b0001, 0, 1'b0, 1'b0);
        check("zero", last_obs, {1'b0, 3'd0, 4'b0000, 2'd0});
        d_in[1] = 12'hFFF;
        run_txn(4'b0010, 1, 1'b0, 1'b0);
        check("minus1", last_obs, {1'b1, 3'd0, 4'b0001, 2'd1});

        // Reset in HOLD with out_ready high: result discarded, pointer cleared.
        @(negedge clk);
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) d_in[i] = 12'($urandom);
        drive_data();
        out_ready = 1'b0;
        #1;
        g = pick(4'hF);
        check("mr_grant", req_ready, 32'(1) << g);
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        check("mr_conv", fsm_state, 1);
        @(negedge clk);
        #1;
        check("mr_hold", out_valid, 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        check("mr_rst_ready", req_ready, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        check("mr_valid", out_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_count", conv_count, 0);
        check("mr_rr", req_ready, 4'b0001);
        req_valid   = 4'h0;
        model_ptr   = 0;
        model_count = 0;

        // Round-robin with all requesters valid continuously.
        last_accept = -1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) d_in[i] = 12'($urandom);
            run_txn(4'hF, 0, 1'b0, 1'b1);
            check("rr_order", last_grant, k % 4);
        end

        // Randomized traffic; count wraps past all-ones along the way.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) d_in[i] = edge_vals[$urandom_range(0, 7)];
                else d_in[i] = 12'($urandom);
            end
            run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b1, 1'b0);
        end

        @(negedge clk);
        req_valid = 4'h0;
        out_ready = 1'b0;
        #1;
        check("final_count", conv_count, model_count);
        check("final_idle", busy, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fpcvt_sched.md
FPCVT_SCHED -- requirements
Module: fpcvt_sched

Interface
REQ-001 The block SHALL expose parameter N_REQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 The block SHALL expose parameter CNT_W, default 16, width of the completion counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  4  per-requester request valid.
REQ-006 req_d  input  48  four 12-bit two's-complement operands; requester i on bits [12i+11:12i].
REQ-007 req_ready  output  4  one-hot grant/accept strobe, combinational.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_s  output  1  result sign.
REQ-011 out_e  output  3  result exponent.
REQ-012 out_f  output  4  result significand.
REQ-013 out_id  output  2  index of the requester that owns the result.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 conv_count  output  CNT_W  number of completed result handshakes.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, CONV and HOLD.
REQ-017 In IDLE, req_ready SHALL be one-hot for the first requester with req_valid=1, searching round-robin from rr_ptr upward modulo 4; otherwise all zero.
REQ-018 In CONV and HOLD, req_ready SHALL be 4'b0000.
REQ-019 On an accept (req_valid[i]&req_ready[i]), the block SHALL latch req_d slice i into d_reg and i into id_reg, set rr_ptr=(i+1) mod 4, and go to CONV.
REQ-020 In CONV, the block SHALL drive d_reg into the single converter instance, register its S/E/F into out_s/out_e/out_f, and go to HOLD.
REQ-021 In HOLD, out_valid SHALL be 1 and out_s/out_e/out_f/out_id SHALL stay stable until out_ready=1.
REQ-022 On out_valid&out_ready, the block SHALL go to IDLE and increment conv_count by 1; the counter SHALL wrap from all-ones to 0.
REQ-023 Latency SHALL be fixed: an accept in cycle t gives out_valid=1 in cycle t+2.
REQ-024 Minimum spacing between accepts SHALL be 3 cycles; no new accept is allowed in the cycle a result handshake completes.
REQ-025 out_valid SHALL be 0 in IDLE and CONV.
REQ-026 Deasserting req_valid while not granted SHALL have no effect; req_d SHALL be sampled only in the accept cycle.
REQ-027 Results SHALL equal the converter's output for d_reg bit-exactly, including saturation (-2048 -> S=1, E=7, F=1111) and zero (S=0, E=0, F=0000).

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set state=IDLE, rr_ptr=0, d_reg=0, id_reg=0, out_s=0, out_e=0, out_f=0, conv_count=0, out_valid=0 and busy=0, regardless of state.
REQ-029 Reset asserted mid-operation (CONV or HOLD) SHALL discard the pending result without incrementing conv_count.
REQ-030 req_ready SHALL be 0 during any cycle with rst=1.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=2'd0, CONV=2'd1, HOLD=2'd2) and the constants DATA_W=12, E_W=3 and F_W=4.
REQ-032 There SHALL be exactly one sub-module: the existing FPCVT converter, instantiated once and unmodified.
REQ-033 Arbitration SHALL be implemented as a local rotate-and-priority-encode; it SHALL NOT be a separate module.

Verification
REQ-034 Single request: requester 0 with D=12'h02C, out_ready=1 -> out_valid in cycle t+2 with S=0, E=2, F=1011, id=0; conv_count=1.
REQ-035 Rounding: requester 2 with D=12'h02E -> S=0, E=2, F=1100, id=2.
REQ-036 Round-robin: all four requesters valid continuously -> grant order 0, 1, 2, 3, 0, with one accept every 3 cycles.
REQ-037 Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, req_ready=0, busy=1 throughout; release -> IDLE next cycle.
REQ-038 Boundaries: D=12'h800 -> S=1, E=7, F=1111; D=12'h000 -> S=0, E=0, F=0000; D=12'hFFF -> S=1, E=0, F=0001.
REQ-039 Mid-operation reset: rst pulsed in HOLD -> out_valid=0 and conv_count unchanged from its reset value 0; next grant starts from requester 0.
